rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port between NREQ writeback requesters, e.g. ALU, load unit and CSR/debug.
- Arbitration is round-robin. The winning write is presented to the register file through a registered output stage.
- A per-register pending-write scoreboard lets issue logic stall on RAW hazards.
- Sits between the execute/memory stages and the register file write port (wr_en/rd/wdata).

---
 rtl/rf_wb_arbiter.sv | 104 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port,
// with a registered write stage and a per-register pending-write scoreboard.
module rf_wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 5,
  parameter int NREQ  = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*ADDR-1:0]    req_rd,
  input  logic [NREQ*WIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rf_wr_en,
  output logic [ADDR-1:0]         rf_rd,
  output logic [WIDTH-1:0]        rf_wdata,
  input  logic                    iss_en,
  input  logic [ADDR-1:0]         iss_rd,
  input  logic [ADDR-1:0]         chk_rs1,
  input  logic [ADDR-1:0]         chk_rs2,
  output logic                    busy_rs1,
  output logic                    busy_rs2,
  output logic [(2**ADDR)-1:0]    busy_vec
);

  localparam int PW   = $clog2(NREQ);
  localparam int NREG = 2**ADDR;

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             wr_en_q, wr_en_d;
  logic [ADDR-1:0]  rd_q, rd_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]  busy_q, busy_d;

  logic [NREQ-1:0]  grant;
  logic             found;
  logic [PW-1:0]    gnt_idx;
  logic [ADDR-1:0]  sel_rd;
  logic [WIDTH-1:0] sel_wdata;
  int               idx;

  // Search from rr_ptr upward, wrapping, for the first valid requester.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (reset_n && !found && req_valid[idx]) begin
        found      = 1'b1;
        gnt_idx    = PW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign sel_rd    = req_rd[int'(gnt_idx)*ADDR +: ADDR];
  assign sel_wdata = req_wdata[int'(gnt_idx)*WIDTH +: WIDTH];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found) rr_ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

    // x0 writes are accepted but never reach the register file.
    wr_en_d = found && (sel_rd != '0);
    rd_d    = found ? sel_rd : rd_q;
    wdata_d = found ? sel_wdata : wdata_q;

    // Set after clear: a newly issued producer supersedes the one retiring.
    busy_d = busy_q;
    if (wr_en_q) busy_d[rd_q] = 1'b0;
    if (iss_en && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
      wr_en_q  <= 1'b0;
      rd_q     <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_en_q  <= wr_en_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  assign req_ready = grant;
  assign rf_wr_en  = wr_en_q;
  assign rf_rd     = rd_q;
  assign rf_wdata  = wdata_q;
  assign busy_vec  = busy_q;

  // The registered write is not yet in the register file, so it still counts as pending.
  assign busy_rs1 = busy_q[chk_rs1] | (wr_en_q && (rd_q == chk_rs1) && (chk_rs1 != '0));
  assign busy_rs2 = busy_q[chk_rs2] | (wr_en_q && (rd_q == chk_rs2) && (chk_rs2 != '0));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a behavioural reference model.
module tb_rf_wb_arbiter;
  localparam int WIDTH = 32;
  localparam int ADDR  = 5;
  localparam int NREQ  = 3;
  localparam int NREG  = 2**ADDR;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*ADDR-1:0]  req_rd;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       req_ready;
  logic                  rf_wr_en;
  logic [ADDR-1:0]       rf_rd;
  logic [WIDTH-1:0]      rf_wdata;
  logic                  iss_en;
  logic [ADDR-1:0]       iss_rd;
  logic [ADDR-1:0]       chk_rs1;
  logic [ADDR-1:0]       chk_rs2;
  logic                  busy_rs1;
  logic                  busy_rs2;
  logic [NREG-1:0]       busy_vec;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.WIDTH(WIDTH), .ADDR(ADDR), .NREQ(NREQ)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_rd(req_rd), .req_wdata(req_wdata), .req_ready(req_ready),
    .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .iss_en(iss_en), .iss_rd(iss_rd), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .busy_vec(busy_vec)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int               m_ptr;
  bit               m_wr;
  int               m_rd;
  logic [WIDTH-1:0] m_data;
  bit [NREG-1:0]    m_busy;
  int               last_gnt;

  function automatic int pick();
    if (!reset_n) return -1;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic bit exp_busy(input int r);
    return m_busy[r] | (m_wr && (m_rd == r) && (r != 0));
  endfunction

  task automatic step();
    int g;
    logic [NREQ-1:0] er;
    @(negedge clk);
    g  = pick();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("rf_wr_en", rf_wr_en, m_wr);
    chk("rf_rd", rf_rd, m_rd);
    chk("rf_wdata", rf_wdata, m_data);
    chk("busy_vec", busy_vec, m_busy);
    chk("busy_rs1", busy_rs1, exp_busy(int'(chk_rs1)));
    chk("busy_rs2", busy_rs2, exp_busy(int'(chk_rs2)));
    @(posedge clk);
    g = pick();
    if (!reset_n) begin
      m_ptr = 0; m_wr = 0; m_rd = 0; m_data = '0; m_busy = '0; last_gnt = -1;
    end else begin
      if (m_wr) m_busy[m_rd] = 1'b0;
      if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      if (g >= 0) begin
        m_ptr  = (g + 1) % NREQ;
        m_rd   = int'(req_rd[g*ADDR +: ADDR]);
        m_data = req_wdata[g*WIDTH +: WIDTH];
        m_wr   = (m_rd != 0);
      end else begin
        m_wr = 0;
      end
      last_gnt = g;
    end
    #1;
  endtask

  // Requester protocol: a pending, unaccepted request holds valid, rd and data.
  logic [NREQ-1:0]       pv = '0, pr = '0;
  logic [NREQ*ADDR-1:0]  prd;
  logic [NREQ*WIDTH-1:0] pdat;
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++)
      if (reset_n && pv[i] && !pr[i])
        assert (req_valid[i] && req_rd[i*ADDR +: ADDR] == prd[i*ADDR +: ADDR]
                && req_wdata[i*WIDTH +: WIDTH] == pdat[i*WIDTH +: WIDTH])
          else $error("requester %0d changed a pending request", i);
    pv   = req_valid;
    pr   = req_ready;
    prd  = req_rd;
    pdat = req_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    m_ptr = 0; m_wr = 0; m_rd = 0; m_data = '0; m_busy = '0; last_gnt = -1;
    reset_n = 1'b0;
    iss_en = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
    req_valid = '1;
    req_rd = '0; req_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_rd[i*ADDR +: ADDR]    = ADDR'(i + 1);
      req_wdata[i*WIDTH +: WIDTH] = WIDTH'(32'h1111_0000 + i);
    end
    #2;

    // Reset with every requester asking
    step();
    chk("rst_ready", req_ready, '0);
    step();
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_busy", busy_vec, '0);
    reset_n = 1'b1;
    #1;
    chk("first_grant", req_ready, 3'b001);

    // Round-robin with all valid
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_wr_en", rf_wr_en, 1);
      chk("rr_rd", rf_rd, (i % 3) + 1);
    end

    // Drain the still-pending requesters 0 and 1
    req_valid = 3'b011;
    step();
    req_valid = 3'b010;
    step();
    req_valid = '0;

    // x0 drop from requester 2; pointer wraps to 0
    req_rd[2*ADDR +: ADDR] = '0;
    req_valid = 3'b100;
    step();
    req_valid = '0;
    chk("x0_wr_en", rf_wr_en, 0);
    chk("x0_busy", busy_vec, '0);

    // Hold-off: requester 1 waits behind requester 0
    req_rd[0*ADDR +: ADDR] = 5'd4;  req_wdata[0*WIDTH +: WIDTH] = 32'h0000_0044;
    req_rd[1*ADDR +: ADDR] = 5'd5;  req_wdata[1*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
    req_valid = 3'b011;
    #1;
    chk("x0_ptr_wrap", req_ready, 3'b001);
    step();
    step();
    chk("hold_wr_en", rf_wr_en, 1);
    chk("hold_rd", rf_rd, 5);
    chk("hold_wdata", rf_wdata, 32'hDEAD_BEEF);
    req_valid = 3'b001;
    step();
    req_valid = '0;

    // Scoreboard set, in-flight visibility, clear, x0 issue
    iss_en = 1'b1; iss_rd = 5'd7; chk_rs1 = 5'd7; chk_rs2 = 5'd3;
    step();
    iss_en = 1'b0;
    chk("sb_set", busy_vec[7], 1);
    chk("sb_rs1", busy_rs1, 1);
    req_rd[0*ADDR +: ADDR] = 5'd7;
    req_valid = 3'b001;
    step();
    req_valid = '0;
    chk("sb_bit_inflight", busy_vec[7], 1);
    chk("sb_rs1_inflight", busy_rs1, 1);
    step();
    chk("sb_clear", busy_vec[7], 0);
    chk("sb_rs1_clear", busy_rs1, 0);
    iss_en = 1'b1; iss_rd = '0;
    step();
    iss_en = 1'b0;
    chk("sb_x0_issue", busy_vec, '0);

    // Set/clear collision on register 9
    iss_en = 1'b1; iss_rd = 5'd9; chk_rs2 = 5'd9;
    step();
    iss_en = 1'b0;
    req_rd[0*ADDR +: ADDR] = 5'd9;
    req_valid = 3'b001;
    step();
    req_valid = '0;
    iss_en = 1'b1; iss_rd = 5'd9;
    step();
    iss_en = 1'b0;
    chk("col_set_wins", busy_vec[9], 1);
    req_valid = 3'b001;
    step();
    req_valid = '0;
    step();
    chk("col_later_clear", busy_vec[9], 0);

    // Randomized traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || last_gnt == i) begin
          if ($urandom_range(0, 2) != 0) begin
            req_valid[i] = 1'b1;
            req_rd[i*ADDR +: ADDR] = ADDR'($urandom_range(0, 11));
            req_wdata[i*WIDTH +: WIDTH] = $urandom;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      iss_en  = ($urandom_range(0, 2) == 0);
      iss_rd  = ADDR'($urandom_range(0, 11));
      chk_rs1 = ADDR'($urandom_range(0, 11));
      chk_rs2 = ADDR'($urandom_range(0, NREG - 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
